priority_scan_encoder: RTL and testbench

//  Parametrised sequential priority encoder. Accepts a WIDTH-bit request vector over a

---
 rtl/priority_scan_encoder.sv | 113 +++++++++++
 tb/tb_priority_scan_encoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_scan_encoder.sv
// Purpose: streams the indices of the set bits of a request vector, one per beat, MSB- or LSB-first, up to MAX_EMIT beats.
// Latency: first beat is valid the cycle after the vector is accepted; one vector in flight, beats+1 cycles per vector.
// Backpressure: out_ready low freezes every out_* signal; a new vector is accepted only once the last beat is taken.
module priority_scan_encoder #(
    parameter int WIDTH    = 8,
    parameter int MAX_EMIT = WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_vec,
    input  logic                     lsb_first,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] out_idx,
    output logic                     out_first,
    output logic                     out_last,
    output logic                     out_none
);
    localparam int IDXW = $clog2(WIDTH);
    // Beat counter must reach MAX_EMIT, which can equal WIDTH.
    localparam int CW   = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  work;
    logic              mode;
    logic [CW-1:0]     cnt;
    logic              first;

    logic [IDXW-1:0]   hi_idx;
    logic [IDXW-1:0]   lo_idx;
    logic [IDXW-1:0]   sel_idx;
    logic              work_zero;
    logic              one_hot;
    logic              at_limit;
    logic              last;
    logic              emit;
    logic              accept;
    logic              beat;

    // Highest and lowest set bit of the work register; later iterations win.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (work[i]) hi_idx = IDXW'(i);
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (work[i]) lo_idx = IDXW'(i);
        end
    end

    assign sel_idx   = mode ? lo_idx : hi_idx;
    assign work_zero = (work == '0);
    assign one_hot   = !work_zero && ((work & (work - WIDTH'(1))) == '0);
    assign at_limit  = (cnt == CW'(MAX_EMIT - 1));
    assign last      = work_zero || one_hot || at_limit;

    assign emit      = (state == EMIT);
    assign accept    = in_valid && (state == IDLE);
    assign beat      = emit && out_ready;

    // All outputs come from registered state; gated so IDLE presents zeros.
    assign in_ready  = (state == IDLE);
    assign out_valid = emit;
    assign out_idx   = emit ? sel_idx : '0;
    assign out_first = emit && first;
    assign out_last  = emit && last;
    assign out_none  = emit && work_zero;

    // Next-state: IDLE -> EMIT on accept, EMIT -> IDLE when the last beat is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = EMIT;
            EMIT:    if (beat && last)  state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Work register, scan mode, beat count and first flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work  <= '0;
            mode  <= 1'b0;
            cnt   <= '0;
            first <= 1'b0;
        end else if (accept) begin
            work  <= in_vec;
            mode  <= lsb_first;
            cnt   <= '0;
            first <= 1'b1;
        end else if (beat) begin
            // Bits left over at the emit limit stay in work and are ignored.
            work  <= work & ~(WIDTH'(1) << sel_idx);
            cnt   <= cnt + CW'(1);
            first <= 1'b0;
        end
    end
endmodule

// File: tb/tb_priority_scan_encoder.sv
module tb_priority_scan_encoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance 0: WIDTH=8 full; 1: WIDTH=8 MAX_EMIT=2; 2: WIDTH=16 full.
    logic [2:0]  in_valid_v = '0;
    logic [2:0]  lsb_v      = '0;
    logic [2:0]  man_rdy    = '0;
    logic [2:0]  rnd_rdy    = '0;
    logic [2:0]  rr         = '0;
    logic [2:0]  out_ready_v;
    logic [15:0] vec_a [3];
    logic [2:0]  in_ready_v, out_valid_v, first_v, last_v, none_v;
    logic [2:0]  idx0, idx1;
    logic [3:0]  idx2;
    logic [3:0]  idx_v [3];

    assign out_ready_v = (rr & rnd_rdy) | (~rr & man_rdy);

    always_comb begin
        idx_v[0] = {1'b0, idx0};
        idx_v[1] = {1'b0, idx1};
        idx_v[2] = idx2;
    end

    priority_scan_encoder #(.WIDTH(8), .MAX_EMIT(8)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_vec(vec_a[0][7:0]), .lsb_first(lsb_v[0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .out_idx(idx0), .out_first(first_v[0]),
        .out_last(last_v[0]), .out_none(none_v[0]));

    priority_scan_encoder #(.WIDTH(8), .MAX_EMIT(2)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_vec(vec_a[1][7:0]), .lsb_first(lsb_v[1]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .out_idx(idx1), .out_first(first_v[1]),
        .out_last(last_v[1]), .out_none(none_v[1]));

    priority_scan_encoder #(.WIDTH(16), .MAX_EMIT(16)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_vec(vec_a[2]), .lsb_first(lsb_v[2]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .out_idx(idx2), .out_first(first_v[2]),
        .out_last(last_v[2]), .out_none(none_v[2]));

    int n_cmp = 0;
    int n_bad = 0;

    // Expected beats of the vector in flight, encoded none<<6 | first<<5 | last<<4 | idx.
    int exp_mem [3][16];
    int exp_n [3];
    int exp_p [3];
    int log_mem [3][16];
    int log_n [3];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int d);
        return (d == 2) ? 16 : 8;
    endfunction

    function automatic int limit_of(input int d);
        return (d == 1) ? 2 : width_of(d);
    endfunction

    // Reference: list set bits in priority order, keep the first MAX_EMIT.
    task automatic model_push(input int d, input logic [15:0] vec, input logic lsb);
        int w;
        int m;
        int idxs[$];
        w = width_of(d);
        m = limit_of(d);
        exp_n[d] = 0;
        exp_p[d] = 0;
        for (int k = 0; k < w; k++) begin
            int i;
            i = lsb ? k : (w - 1 - k);
            if (vec[i] && idxs.size() < m) idxs.push_back(i);
        end
        if (idxs.size() == 0) begin
            exp_mem[d][0] = (1 << 6) | (1 << 5) | (1 << 4);
            exp_n[d] = 1;
        end else begin
            foreach (idxs[j]) begin
                exp_mem[d][j] = ((j == 0) ? (1 << 5) : 0)
                              | ((j == idxs.size() - 1) ? (1 << 4) : 0)
                              | idxs[j];
            end
            exp_n[d] = idxs.size();
        end
    endtask

    // Monitor: on every falling edge compare each instance with the model.
    initial begin
        for (int d = 0; d < 3; d++) begin
            exp_n[d] = 0; exp_p[d] = 0; log_n[d] = 0;
        end
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int d = 0; d < 3; d++) begin
                    bit busy;
                    int got;
                    busy = exp_p[d] < exp_n[d];
                    check($sformatf("in_ready[%0d]", d), int'(in_ready_v[d]), int'(!busy));
                    check($sformatf("out_valid[%0d]", d), int'(out_valid_v[d]), int'(busy));
                    if (busy) begin
                        got = (int'(none_v[d]) << 6) | (int'(first_v[d]) << 5)
                            | (int'(last_v[d]) << 4) | int'(idx_v[d]);
                        check($sformatf("beat[%0d]", d), got, exp_mem[d][exp_p[d]]);
                        if (out_ready_v[d]) begin
                            if (log_n[d] < 16) log_mem[d][log_n[d]] = int'(idx_v[d]);
                            log_n[d]++;
                            exp_p[d]++;
                        end
                    end else if (in_valid_v[d]) begin
                        model_push(d, vec_a[d], lsb_v[d]);
                    end
                end
            end
        end
    end

    // Random consumer backpressure for instances in random-ready mode.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) rnd_rdy[d] = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input int d, input logic [15:0] vec, input logic lsb);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        in_valid_v[d] = 1'b1;
        vec_a[d] = vec;
        lsb_v[d] = lsb;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready_v[d]) begin ok = 1; break; end
        end
        if (!ok) check($sformatf("send_timeout[%0d]", d), 0, 1);
        @(posedge clk);
        #1;
        in_valid_v[d] = 1'b0;
        // Input changes during the scan must not matter.
        vec_a[d] = 16'($urandom);
        lsb_v[d] = 1'($urandom);
    endtask

    task automatic wait_idle(input int d);
        bit ok;
        ok = 0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (exp_p[d] >= exp_n[d] && in_ready_v[d]) begin ok = 1; break; end
        end
        if (!ok) check($sformatf("idle_timeout[%0d]", d), 0, 1);
    endtask

    task automatic check_seq(input int d, input int n, input int e0, input int e1, input int e2);
        int e[3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        check($sformatf("seq_len[%0d]", d), log_n[d], n);
        for (int j = 0; j < n && j < log_n[d]; j++)
            check($sformatf("seq[%0d][%0d]", d, j), log_mem[d][j], e[j]);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) vec_a[d] = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_in_ready[%0d]", d), int'(in_ready_v[d]), 1);
            check($sformatf("rst_out_valid[%0d]", d), int'(out_valid_v[d]), 0);
            check($sformatf("rst_idx[%0d]", d), int'(idx_v[d]), 0);
            check($sformatf("rst_flags[%0d]", d),
                  int'({first_v[d], last_v[d], none_v[d]}), 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        man_rdy = 3'b111;

        // Ordering, MSB first.
        log_n[0] = 0; send(0, 16'h00A2, 1'b0); wait_idle(0);
        check_seq(0, 3, 7, 5, 1);
        // LSB first.
        log_n[0] = 0; send(0, 16'h00A2, 1'b1); wait_idle(0);
        check_seq(0, 3, 1, 5, 7);
        // Empty vector.
        log_n[0] = 0; send(0, 16'h0000, 1'b0); wait_idle(0);
        check_seq(0, 1, 0, 0, 0);

        // Backpressure during beat 2.
        log_n[0] = 0;
        man_rdy[0] = 1'b0;
        send(0, 16'h00A2, 1'b0);
        man_rdy[0] = 1'b1;
        @(posedge clk);
        #1;
        man_rdy[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_idx", int'(idx_v[0]), 5);
        end
        @(posedge clk);
        #1;
        man_rdy[0] = 1'b1;
        @(negedge clk);
        check("bp_hold_idx", int'(idx_v[0]), 5);
        wait_idle(0);
        check_seq(0, 3, 7, 5, 1);

        // Emit limit and wide vector.
        log_n[1] = 0; send(1, 16'h00FF, 1'b0); wait_idle(1);
        check_seq(1, 2, 7, 6, 0);
        log_n[2] = 0; send(2, 16'h8001, 1'b0); wait_idle(2);
        check_seq(2, 2, 15, 0, 0);

        // Reset in the middle of a scan.
        man_rdy[0] = 1'b0;
        send(0, 16'h00FF, 1'b0);
        man_rdy[0] = 1'b1;
        @(posedge clk);
        #1;
        man_rdy[0] = 1'b0;
        check("mid_idx", int'(idx_v[0]), 6);
        #2;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin exp_n[d] = 0; exp_p[d] = 0; end
        #1;
        check("mid_rst_out_valid", int'(out_valid_v[0]), 0);
        check("mid_rst_in_ready", int'(in_ready_v[0]), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        man_rdy[0] = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready_v[0]), 1);
        log_n[0] = 0; send(0, 16'h0004, 1'b0); wait_idle(0);
        check_seq(0, 1, 2, 0, 0);

        // Randomized vectors with random consumer stalls.
        rr = 3'b111;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 60; i++) begin
                logic [15:0] v;
                v = 16'($urandom);
                if ($urandom_range(0, 7) == 0) v = '0;
                send(d, v, 1'($urandom));
                wait_idle(d);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
